// File: rtl/sram22_ctrl_pkg.sv
// Shared sizes, FSM encoding and arbitration helpers for the SRAM22 two-requester controller.
package sram22_ctrl_pkg;
    localparam int DEF_DATA_WIDTH  = 64;
    localparam int DEF_ADDR_WIDTH  = 10;
    localparam int DEF_WMASK_WIDTH = 8;
    localparam int DEPTH           = 1024;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Round-robin pick between two eligible requesters; last = index granted most recently.
    function automatic logic rr_pick(input logic [1:0] elig, input logic last);
        logic pick;
        case (elig)
            2'b11:   pick = ~last;
            2'b10:   pick = 1'b1;
            2'b01:   pick = 1'b0;
            default: pick = 1'b0;
        endcase
        return pick;
    endfunction

    function automatic logic [1:0] grant_onehot(input logic any, input logic idx);
        logic [1:0] oh;
        if (any) begin
            oh = idx ? 2'b10 : 2'b01;
        end else begin
            oh = 2'b00;
        end
        return oh;
    endfunction
endpackage

// File: rtl/sram22_rsp_slot.sv
// One-deep read-response holding slot: tracks the in-flight read and keeps the captured
// macro data until the requester consumes it.
module sram22_rsp_slot
    import sram22_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  issue,
    input  logic                  rsp_ready,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  free
);
    logic                  pending_r;
    logic                  valid_r;
    logic [DATA_WIDTH-1:0] data_r;

    // Pending marks the cycle the macro output belongs to us; capture wins over a same-cycle pop.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pending_r <= 1'b0;
            valid_r   <= 1'b0;
            data_r    <= {DATA_WIDTH{1'b0}};
        end else begin
            pending_r <= issue;
            if (pending_r) begin
                valid_r <= 1'b1;
                data_r  <= sram_dout;
            end else if (valid_r && rsp_ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign free      = ~pending_r & (~valid_r | rsp_ready);
    assign rsp_valid = valid_r;
    assign rsp_rdata = data_r;
endmodule

// File: rtl/sram22_arb2_ctrl.sv
// Two-requester round-robin front end for a single-port SRAM macro, with a power-on
// clear sweep of the whole array before any request is accepted.
module sram22_arb2_ctrl
    import sram22_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WMASK_WIDTH = DEF_WMASK_WIDTH
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [1:0]               req_we,
    input  logic [2*WMASK_WIDTH-1:0] req_wmask,
    input  logic [2*ADDR_WIDTH-1:0]  req_addr,
    input  logic [2*DATA_WIDTH-1:0]  req_wdata,
    output logic [1:0]               rsp_valid,
    input  logic [1:0]               rsp_ready,
    output logic [2*DATA_WIDTH-1:0]  rsp_rdata,
    output logic                     sram_ce,
    output logic                     sram_we,
    output logic [WMASK_WIDTH-1:0]   sram_wmask,
    output logic [ADDR_WIDTH-1:0]    sram_addr,
    output logic [DATA_WIDTH-1:0]    sram_din,
    input  logic [DATA_WIDTH-1:0]    sram_dout,
    output logic                     init_done
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                  state_r;
    state_e                  state_nx_s;
    logic [ADDR_WIDTH-1:0]   init_cnt_r;
    logic                    last_r;
    logic                    init_done_r;
    logic [1:0]              slot_free_s;
    logic [1:0]              elig_s;
    logic                    grant_any_s;
    logic                    grant_idx_s;
    logic [1:0]              read_issue_s;

    // Next-state: the clear sweep ends after the last address has been written.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            INIT: begin
                if (init_cnt_r == LAST_ADDR) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = INIT;
                end
            end
            RUN:     state_nx_s = RUN;
            default: state_nx_s = INIT;
        endcase
    end

    // A read may only be granted when its response slot can absorb the result.
    always_comb begin
        elig_s = 2'b00;
        if (state_r == RUN) begin
            elig_s = req_valid & (req_we | slot_free_s);
        end else begin
            elig_s = 2'b00;
        end
        grant_any_s  = |elig_s;
        grant_idx_s  = rr_pick(elig_s, last_r);
        req_ready    = grant_onehot(grant_any_s, grant_idx_s);
        read_issue_s = req_ready & ~req_we;
    end

    // Macro command mux: clear pattern in INIT, granted requester's fields in RUN.
    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_wmask = {WMASK_WIDTH{1'b0}};
        sram_addr  = {ADDR_WIDTH{1'b0}};
        sram_din   = {DATA_WIDTH{1'b0}};
        case (state_r)
            INIT: begin
                sram_ce    = rstb;
                sram_we    = 1'b1;
                sram_wmask = {WMASK_WIDTH{1'b1}};
                sram_addr  = init_cnt_r;
                sram_din   = {DATA_WIDTH{1'b0}};
            end
            RUN: begin
                if (grant_any_s) begin
                    sram_ce    = 1'b1;
                    sram_we    = grant_idx_s ? req_we[1] : req_we[0];
                    sram_wmask = grant_idx_s ? req_wmask[2*WMASK_WIDTH-1:WMASK_WIDTH]
                                             : req_wmask[WMASK_WIDTH-1:0];
                    sram_addr  = grant_idx_s ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                             : req_addr[ADDR_WIDTH-1:0];
                    sram_din   = grant_idx_s ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                             : req_wdata[DATA_WIDTH-1:0];
                end else begin
                    sram_ce = 1'b0;
                end
            end
            default: sram_ce = 1'b0;
        endcase
    end

    // FSM, clear counter, round-robin pointer and init_done flag.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r     <= INIT;
            init_cnt_r  <= {ADDR_WIDTH{1'b0}};
            last_r      <= 1'b1;
            init_done_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (state_r == INIT) begin
                init_cnt_r <= init_cnt_r + ADDR_ONE;
            end
            if (grant_any_s) begin
                last_r <= grant_idx_s;
            end
            init_done_r <= (state_nx_s == RUN);
        end
    end

    assign init_done = init_done_r;

    sram22_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot0 (
        .clk       (clk),
        .rstb      (rstb),
        .issue     (read_issue_s[0]),
        .rsp_ready (rsp_ready[0]),
        .sram_dout (sram_dout),
        .rsp_valid (rsp_valid[0]),
        .rsp_rdata (rsp_rdata[DATA_WIDTH-1:0]),
        .free      (slot_free_s[0])
    );

    sram22_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot1 (
        .clk       (clk),
        .rstb      (rstb),
        .issue     (read_issue_s[1]),
        .rsp_ready (rsp_ready[1]),
        .sram_dout (sram_dout),
        .rsp_valid (rsp_valid[1]),
        .rsp_rdata (rsp_rdata[2*DATA_WIDTH-1:DATA_WIDTH]),
        .free      (slot_free_s[1])
    );
endmodule

// File: tb/tb_sram22_arb2_ctrl.sv
// Self-checking bench: behavioural SRAM macro plus a transaction-level reference model
// (expected memory contents and per-requester response queues).
module tb_sram22_arb2_ctrl;
    import sram22_ctrl_pkg::*;

    localparam int DW = 64;
    localparam int AW = 10;
    localparam int MW = 8;

    logic            clk;
    logic            rstb;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [2*MW-1:0] req_wmask;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [2*DW-1:0] rsp_rdata;
    logic            sram_ce;
    logic            sram_we;
    logic [MW-1:0]   sram_wmask;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_din;
    logic [DW-1:0]   sram_dout;
    logic            init_done;

    sram22_arb2_ctrl dut (
        .clk        (clk),
        .rstb       (rstb),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_wmask  (req_wmask),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout),
        .init_done  (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural macro: byte-masked write, registered read output held until the next read.
    logic [DW-1:0] macro_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < MW; b++) begin
                    if (sram_wmask[b]) macro_mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
                end
            end else begin
                sram_dout <= macro_mem[sram_addr];
            end
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        int            vis;
    } rsp_t;

    logic [DW-1:0] ref_mem [0:DEPTH-1];
    rsp_t          q0[$];
    rsp_t          q1[$];
    int            cyc;
    bit            last_g;
    logic [1:0]    obs_ready;
    logic          obs_ce;
    int            n_checks;
    int            n_errors;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++) begin
            if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    // One RUN cycle: predict from the rules, compare, then advance the model at the clock edge.
    task automatic step();
        logic [1:0]    exp_v;
        logic [1:0]    fre;
        logic [1:0]    elig;
        logic [1:0]    exp_ready;
        int            g;
        int            sz0;
        int            sz1;
        logic [AW-1:0] ga;
        logic [MW-1:0] gm;
        logic [DW-1:0] gd;
        logic          gw;
        rsp_t          e;
        #1;
        sz0 = q0.size();
        sz1 = q1.size();
        exp_v[0] = (sz0 > 0) && (q0[0].vis <= cyc);
        exp_v[1] = (sz1 > 0) && (q1[0].vis <= cyc);
        fre[0] = (sz0 == 0) || (sz0 == 1 && exp_v[0] && rsp_ready[0]);
        fre[1] = (sz1 == 0) || (sz1 == 1 && exp_v[1] && rsp_ready[1]);
        elig = req_valid & (req_we | fre);
        if (elig == 2'b11) g = last_g ? 0 : 1;
        else if (elig[0]) g = 0;
        else if (elig[1]) g = 1;
        else g = -1;
        exp_ready = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
        ga = (g == 1) ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
        gm = (g == 1) ? req_wmask[2*MW-1:MW] : req_wmask[MW-1:0];
        gd = (g == 1) ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
        gw = (g == 1) ? req_we[1] : req_we[0];
        obs_ready = req_ready;
        obs_ce    = sram_ce;
        check_eq("req_ready", {62'd0, req_ready}, {62'd0, exp_ready});
        check_eq("sram_ce", {63'd0, sram_ce}, {63'd0, (g >= 0)});
        if (g >= 0) begin
            check_eq("sram_we", {63'd0, sram_we}, {63'd0, gw});
            check_eq("sram_addr", {54'd0, sram_addr}, {54'd0, ga});
            check_eq("sram_wmask", {56'd0, sram_wmask}, {56'd0, gm});
            check_eq("sram_din", sram_din, gd);
        end
        check_eq("rsp_valid", {62'd0, rsp_valid}, {62'd0, exp_v});
        if (exp_v[0]) check_eq("rsp_rdata0", rsp_rdata[DW-1:0], q0[0].data);
        if (exp_v[1]) check_eq("rsp_rdata1", rsp_rdata[2*DW-1:DW], q1[0].data);
        @(posedge clk);
        if (exp_v[0] && rsp_ready[0]) void'(q0.pop_front());
        if (exp_v[1] && rsp_ready[1]) void'(q1.pop_front());
        if (g >= 0) begin
            last_g = (g == 1);
            if (gw) begin
                ref_mem[ga] = merge(ref_mem[ga], gd, gm);
            end else begin
                e.data = ref_mem[ga];
                e.vis  = cyc + 2;
                if (g == 0) q0.push_back(e);
                else q1.push_back(e);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic reset_checks();
        #1;
        check_eq("rst_req_ready", {62'd0, req_ready}, 64'd0);
        check_eq("rst_sram_ce", {63'd0, sram_ce}, 64'd0);
        check_eq("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        check_eq("rst_rdata0", rsp_rdata[DW-1:0], 64'd0);
        check_eq("rst_rdata1", rsp_rdata[2*DW-1:DW], 64'd0);
        check_eq("rst_init_done", {63'd0, init_done}, 64'd0);
    endtask

    // Starts at a negedge with rstb just released; ends at the negedge of the first RUN cycle.
    task automatic init_sweep();
        q0.delete();
        q1.delete();
        last_g = 1'b1;
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = 64'd0;
        for (int k = 0; k < DEPTH; k++) begin
            req_valid = 2'b11;
            req_we    = 2'($urandom_range(0, 3));
            #1;
            check_eq("init_ce", {63'd0, sram_ce}, 64'd1);
            check_eq("init_we", {63'd0, sram_we}, 64'd1);
            check_eq("init_wmask", {56'd0, sram_wmask}, 64'hFF);
            check_eq("init_din", sram_din, 64'd0);
            check_eq("init_addr", {54'd0, sram_addr}, 64'(k));
            check_eq("init_ready", {62'd0, req_ready}, 64'd0);
            check_eq("init_rsp_valid", {62'd0, rsp_valid}, 64'd0);
            check_eq("init_done_low", {63'd0, init_done}, 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 2'b00;
        #1;
        check_eq("init_done_high", {63'd0, init_done}, 64'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        rstb      = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_wmask = 16'h0000;
        req_addr  = 20'd0;
        req_wdata = 128'd0;
        rsp_ready = 2'b00;
        sram_dout = 64'd0;
        for (int a = 0; a < DEPTH; a++) macro_mem[a] = {$urandom, $urandom};
        #2 rstb = 1'b0;
        @(negedge clk);
        reset_checks();
        @(negedge clk);
        rstb = 1'b1;
        init_sweep();

        // Both requesters reading continuously: strict alternation starting with requester 0.
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {10'd2, 10'd1};
        rsp_ready = 2'b11;
        for (int k = 0; k < 8; k++) begin
            step();
            check_eq("alt_grant", {62'd0, obs_ready}, (k % 2 == 0) ? 64'd1 : 64'd2);
            check_eq("alt_ce", {63'd0, obs_ce}, 64'd1);
        end
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) step();

        // Partial-mask write then read-back of the same word.
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        req_we    = 2'b01;
        req_addr  = {10'd0, 10'd5};
        req_wmask = {8'h00, 8'h0F};
        req_wdata = {64'd0, 64'h0123_4567_89AB_CDEF};
        step();
        check_eq("wr5_grant", {62'd0, obs_ready}, 64'd1);
        req_we = 2'b00;
        step();
        check_eq("rd5_grant", {62'd0, obs_ready}, 64'd1);
        req_valid = 2'b00;
        step();
        #1;
        check_eq("rd5_valid", {63'd0, rsp_valid[0]}, 64'd1);
        check_eq("rd5_data", rsp_rdata[DW-1:0], 64'h0000_0000_89AB_CDEF);
        step();
        rsp_ready = 2'b11;
        step();

        // Blocked response slot holds back further reads but not writes.
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        req_we    = 2'b00;
        req_addr  = {10'd7, 10'd0};
        step();
        check_eq("blk_first", {62'd0, obs_ready}, 64'd2);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("blk_hold", {62'd0, obs_ready}, 64'd0);
        end
        req_we    = 2'b10;
        req_addr  = {10'd9, 10'd0};
        req_wmask = {8'hFF, 8'h00};
        req_wdata = {$urandom, $urandom, 64'd0};
        for (int k = 0; k < 2; k++) begin
            step();
            check_eq("blk_write", {62'd0, obs_ready}, 64'd2);
        end
        req_we    = 2'b00;
        rsp_ready = 2'b10;
        step();
        check_eq("blk_release", {62'd0, obs_ready}, 64'd2);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) step();

        // Randomised traffic over a small address window to provoke hazards.
        for (int k = 0; k < 3000; k++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_we    = 2'($urandom_range(0, 3));
            req_addr  = {10'($urandom_range(0, 15)), 10'($urandom_range(0, 15))};
            req_wmask = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            req_wdata = {$urandom, $urandom, $urandom, $urandom};
            rsp_ready = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
            step();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) step();

        // Reset one cycle after a read grant discards it and restarts the clear sweep.
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr  = {10'd0, 10'd3};
        step();
        check_eq("mid_rd_grant", {62'd0, obs_ready}, 64'd1);
        req_valid = 2'b00;
        rstb = 1'b0;
        reset_checks();
        @(posedge clk);
        @(negedge clk);
        reset_checks();
        @(negedge clk);
        rstb = 1'b1;
        init_sweep();
        for (int k = 0; k < 200; k++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_we    = 2'($urandom_range(0, 3));
            req_addr  = {10'($urandom_range(0, 15)), 10'($urandom_range(0, 15))};
            req_wmask = 16'($urandom);
            req_wdata = {$urandom, $urandom, $urandom, $urandom};
            rsp_ready = 2'($urandom_range(0, 3));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sram22_arb2_ctrl.md
SRAM22_ARB2_CTRL -- requirements
Module: sram22_arb2_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 64, data word width in bits.
REQ-002 Parameter: ADDR_WIDTH, 10, word address width (depth 2**ADDR_WIDTH = 1024).
REQ-003 Parameter: WMASK_WIDTH, 8, byte-lane write-mask width (DATA_WIDTH/WMASK_WIDTH = 8 bits per lane).
REQ-004 Port: clk  input  1  single clock; every flop is rising-edge on clk.
REQ-005 Port: rstb  input  1  reset, asynchronous, active-low.
REQ-006 Port: req_valid  input  2  per-requester request valid; bit i is requester i.
REQ-007 Port: req_ready  output  2  per-requester request accepted this cycle.
REQ-008 Port: req_we  input  2  1 = write, 0 = read.
REQ-009 Port: req_wmask  input  2*WMASK_WIDTH  byte-lane mask; slice i belongs to requester i.
REQ-010 Port: req_addr  input  2*ADDR_WIDTH  word address per requester.
REQ-011 Port: req_wdata  input  2*DATA_WIDTH  write data per requester.
REQ-012 Port: rsp_valid  output  2  read data available per requester.
REQ-013 Port: rsp_ready  input  2  requester consumes its response.
REQ-014 Port: rsp_rdata  output  2*DATA_WIDTH  read data per requester.
REQ-015 Port: sram_ce, sram_we  output  1 each  macro chip enable and write enable.
REQ-016 Port: sram_wmask  output  WMASK_WIDTH; sram_addr  output  ADDR_WIDTH; sram_din  output  DATA_WIDTH; macro controls.
REQ-017 Port: sram_dout  input  DATA_WIDTH  macro read data; valid the cycle after a read is issued, held until the next read.
REQ-018 Port: init_done  output  1  high once memory clear completes.

Function
REQ-019 The FSM SHALL have two states: INIT (entered on reset) and RUN.
REQ-020 In INIT: sram_ce=1, sram_we=1, sram_wmask=all ones, sram_din=0, sram_addr=init counter; the counter starts at 0 and increments each cycle; after the cycle with addr=1023 the FSM SHALL go to RUN (1024 cycles total), and init_done SHALL rise the first RUN cycle.
REQ-021 In INIT, req_ready SHALL be 0 for both requesters.
REQ-022 In RUN, requester i is eligible when req_valid[i] is high and either req_we[i]=1 or its response slot is free.
REQ-022a A slot is free when (pending_i + rsp_valid[i]) == 0, or when it equals 1 with rsp_valid[i] & rsp_ready[i] high.
REQ-023 At most one requester SHALL be granted per cycle; if one is eligible, grant it; if both are eligible, grant the one not granted last (round-robin).
REQ-023a The last-grant pointer SHALL update on every grant.
REQ-024 req_ready[i] SHALL be high only in the cycle requester i is granted; req_ready MAY depend combinationally on req_valid/req_we; requesters SHALL NOT make req_valid depend on req_ready.
REQ-025 On a grant, sram_ce=1 and sram_we/wmask/addr/din SHALL equal the granted requester's fields in the same cycle; with no grant in RUN, sram_ce=0.
REQ-026 A read granted in cycle t SHALL set pending_i for cycle t+1, capture sram_dout into slot i at the end of t+1, and assert rsp_valid[i] from t+2.
REQ-026a rsp_valid[i] and rsp_rdata slice i SHALL hold until rsp_valid[i] & rsp_ready[i].
REQ-027 Writes SHALL produce no response; a write with wmask=0 is still issued (ce=1) and changes nothing.
REQ-028 Accesses SHALL take effect in grant order: a read granted after a write to the same address returns the new data.
REQ-029 Simultaneous slot pop and capture on the same requester SHALL leave rsp_valid=1 with the new data.

Reset
REQ-030 When rstb is low, the block SHALL asynchronously set: state=INIT, init counter=0, last-grant pointer=1 (requester 0 wins the first tie), pending=0, rsp_valid=0, rsp_rdata=0, init_done=0.
REQ-030a Combinational outputs during reset SHALL be: req_ready=0, sram_ce=0.
REQ-031 Reset mid-operation SHALL discard in-flight reads and undelivered responses and restart INIT from address 0.

Structure
REQ-032 Package sram22_ctrl_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH/WMASK_WIDTH defaults, DEPTH=1024 and the state enum {INIT, RUN}.
REQ-033 The per-requester response slot (pending flag, valid, data register) SHALL be sub-module sram22_rsp_slot, instantiated twice.

Verification
REQ-034 Reset, then 1024 cycles: sram addr sweeps 0..1023 with we=1, wmask=8'hFF, din=0; init_done=1 in cycle 1025; req_ready=0 throughout INIT.
REQ-035 After init, req0 writes addr 5 = 64'h0123_4567_89AB_CDEF, wmask=8'h0F; then reads addr 5 -> rsp_rdata0 = 64'h0000_0000_89AB_CDEF two cycles after the read grant.
REQ-036 Both requesters continuously valid (reads, rsp_ready=1) -> grants alternate 0,1,0,1, first grant to 0; sram_ce=1 every cycle.
REQ-037 req1 read with rsp_ready[1]=0 -> a second read from req1 is not granted until rsp_ready[1] pulses; writes from req1 are still granted meanwhile.
REQ-038 Assert rstb low one cycle after a read grant -> no rsp_valid appears, and INIT restarts at addr 0.
